apb_irq_ctrl: RTL

// - APB-programmable interrupt controller sitting directly downstream of apb_timer: consumes its
//   irq_o vector (overflow/cmp pairs per timer) plus any other event lines.
// - Detects rising edges, latches them into pending bits, masks them and presents one prioritised

---
 rtl/apb_irq_ctrl_if.sv | 23 ++
 rtl/apb_irq_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/apb_irq_ctrl_if.sv
// APB slave bus bundle for apb_irq_ctrl; clock and reset stay outside as plain ports.
interface apb_irq_ctrl_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_irq_ctrl.sv
// Edge-detecting, maskable, lowest-index-first interrupt controller with an APB register file.
// One request (line + ID) is presented and held stable until acknowledged or withdrawn by software.
module apb_irq_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_IRQ        = 4
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  apb_irq_ctrl_if.slave              apb,
  input  logic [NUM_IRQ-1:0]         irq_i,
  output logic                       irq_o,
  output logic [$clog2(NUM_IRQ)-1:0] irq_id_o,
  input  logic                       irq_ack_i
);
  localparam int ID_W = $clog2(NUM_IRQ);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  state_e                    state_q;
  logic [NUM_IRQ-1:0]        mask_q, mask_d;
  logic [NUM_IRQ-1:0]        pend_q, pend_d;
  logic [NUM_IRQ-1:0]        irq_q;
  logic [ID_W-1:0]           id_q;
  logic                      irq_o_q;
  logic [31:0]               prdata_q;
  logic                      pslverr_q;

  logic [NUM_IRQ-1:0]        edge_s, set_s, clr_s, ack_clr_s, elig_s;
  logic [31:0]               rdata_s;
  logic [2:0]                sel_s;
  logic                      wr_s, setup_s, unmapped_s;
  logic [APB_ADDR_WIDTH-1:0] unused_addr_s;
  logic [31:0]               unused_wdata_s;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    lowest_idx = {ID_W{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  assign unused_addr_s  = apb.PADDR;
  assign unused_wdata_s = apb.PWDATA;

  // Register decode, pending-bit arithmetic and read mux (sampled in the setup phase)
  always_comb begin
    sel_s      = apb.PADDR[4:2];
    wr_s       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    setup_s    = apb.PSEL & ~apb.PENABLE;
    unmapped_s = (sel_s >= 3'd5);
    edge_s     = irq_i & ~irq_q;
    mask_d     = mask_q;
    set_s      = {NUM_IRQ{1'b0}};
    clr_s      = {NUM_IRQ{1'b0}};
    rdata_s    = 32'h0000_0000;
    if (wr_s) begin
      case (sel_s)
        3'd0:    mask_d = apb.PWDATA[NUM_IRQ-1:0];
        3'd2:    set_s  = apb.PWDATA[NUM_IRQ-1:0];
        3'd3:    clr_s  = apb.PWDATA[NUM_IRQ-1:0];
        default: mask_d = mask_q;
      endcase
    end else begin
      mask_d = mask_q;
    end
    case (sel_s)
      3'd0:    rdata_s[NUM_IRQ-1:0] = mask_q;
      3'd1:    rdata_s[NUM_IRQ-1:0] = pend_q;
      3'd4: begin
        rdata_s[31]       = irq_o_q;
        rdata_s[ID_W-1:0] = id_q;
      end
      default: rdata_s = 32'h0000_0000;
    endcase
    if ((state_q == S_REQ) && irq_ack_i) begin
      ack_clr_s = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id_q;
    end else begin
      ack_clr_s = {NUM_IRQ{1'b0}};
    end
    // New edges and SET are ORed in after the clears so an event is never lost
    pend_d = (pend_q & ~(clr_s | ack_clr_s)) | edge_s | set_s;
    elig_s = pend_q & mask_q;
  end

  // All state: registers, edge history, APB response and the request FSM
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      mask_q    <= {NUM_IRQ{1'b0}};
      pend_q    <= {NUM_IRQ{1'b0}};
      irq_q     <= {NUM_IRQ{1'b0}};
      id_q      <= {ID_W{1'b0}};
      irq_o_q   <= 1'b0;
      prdata_q  <= 32'h0000_0000;
      pslverr_q <= 1'b0;
    end else begin
      irq_q     <= irq_i;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      prdata_q  <= (setup_s && !apb.PWRITE) ? rdata_s : 32'h0000_0000;
      pslverr_q <= setup_s & unmapped_s;
      case (state_q)
        S_IDLE: begin
          if (elig_s != {NUM_IRQ{1'b0}}) begin
            state_q <= S_REQ;
            id_q    <= lowest_idx(elig_s);
            irq_o_q <= 1'b1;
          end else begin
            irq_o_q <= 1'b0;
          end
        end
        S_REQ: begin
          // Ack, or software masking/clearing the presented line, ends the request
          if (irq_ack_i || !mask_q[id_q] || !pend_q[id_q]) begin
            state_q <= S_IDLE;
            irq_o_q <= 1'b0;
          end else begin
            irq_o_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          irq_o_q <= 1'b0;
        end
      endcase
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = pslverr_q;
  assign irq_o       = irq_o_q;
  assign irq_id_o    = id_q;
endmodule
